// File: rtl/spi_tft_receiver_pkg.sv
// Shared definitions for the TFT SPI link, used by both the receiver and the controller side.
package spi_tft_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam int   SPI_BYTE_BITS = 8;
  localparam logic DC_CMD        = 1'b0;
  localparam logic DC_DATA       = 1'b1;

endpackage

// File: rtl/spi_tft_receiver_sync_edge.sv
// N-stage synchroniser for an asynchronous pin with registered rise/fall pulses,
// so an edge pulse lags the synchronised level by exactly one clk.
module spi_sync_edge
  import spi_tft_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_tft_receiver.sv
// SPI target receiver for the TFT write link: deserialises MSB-first bytes framed by cs,
// tags each with dc, and offers them on a single-entry valid/ready output with overrun tracking.
module spi_tft_receiver
  import spi_tft_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_ON_RISE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_first,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clr_overrun
);

  localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] dc_sync_q;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   dc_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   sample;

  rx_state_t              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   first_pend_q, first_pend_d;
  logic [SPI_BYTE_BITS-2:0] shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_dc_q, rx_dc_d;
  logic                   rx_first_q, rx_first_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   byte_done;
  logic                   partial;
  logic                   xfer;
  logic                   drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      dc_sync_q   <= {SYNC_STAGES{DC_CMD}};
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  // The extra register inside the edge detector gives the fixed SYNC_STAGES+2 latency.
  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (spi_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign sample = (SAMPLE_ON_RISE != 0) ? sclk_rise : sclk_fall;
  assign xfer   = rx_valid_q & rx_ready;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    first_pend_d = first_pend_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_dc_d      = rx_dc_q;
    rx_first_d   = rx_first_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    byte_done    = 1'b0;
    partial      = 1'b0;
    drop         = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d    = 3'd0;
        first_pend_d = 1'b1;
        if (!cs_s) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sample) begin
          shift_d = {shift_q[SPI_BYTE_BITS-3:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            byte_done = 1'b1;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        // A byte completing on the same cycle cs rises is kept, not flagged.
        partial = (bit_cnt_q != 3'd0 || sample) && !byte_done;
        if (cs_s) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          frame_err_d = partial;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase

    if (byte_done) begin
      first_pend_d = 1'b0;
      if (!rx_valid_q || xfer) begin
        rx_data_d  = {shift_q, mosi_s};
        rx_dc_d    = dc_s;
        rx_first_d = first_pend_q;
        rx_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (xfer) begin
      rx_valid_d = 1'b0;
    end

    overrun_d = (overrun_q & ~clr_overrun) | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      first_pend_q <= 1'b1;
      rx_data_q    <= 8'h00;
      rx_dc_q      <= DC_CMD;
      rx_first_q   <= 1'b0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      first_pend_q <= first_pend_d;
      rx_data_q    <= rx_data_d;
      rx_dc_q      <= rx_dc_d;
      rx_first_q   <= rx_first_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Shift data needs no reset: bit_cnt gates when it is consumed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign rx_data   = rx_data_q;
  assign rx_dc     = rx_dc_q;
  assign rx_first  = rx_first_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_tft_receiver.sv
// Scoreboard bench for spi_tft_receiver: directed link scenarios plus randomised frames.
module tb_spi_tft_receiver;

  localparam int SS  = 2;
  localparam int SOR = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       dc;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_dc = 1'b0;
  logic       ready_dir = 1'b1;
  logic       rand_mode = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_first;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   half = 4;
  int   last_sample_cyc = 0;
  int   last_rise_cyc = 0;
  int   valid_hi_cnt = 0;
  int   fe_cnt = 0;
  logic valid_prev = 1'b0;
  exp_t sb_q[$];
  event last_bit_ev;

  assign rx_ready = rand_mode ? rnd_ready : ready_dir;

  spi_tft_receiver #(
    .SYNC_STAGES    (SS),
    .SAMPLE_ON_RISE (SOR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_dc      (spi_dc),
    .rx_data     (rx_data),
    .rx_dc       (rx_dc),
    .rx_first    (rx_first),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_err) fe_cnt++;
        if (rx_valid) valid_hi_cnt++;
        if (rx_valid && !valid_prev) last_rise_cyc = cyc;
        if (rx_valid && rx_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=0x%0h required=none", rx_data);
          end else begin
            e = sb_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(e.d));
            check("rx_dc", 32'(rx_dc), 32'(e.dc));
            check("rx_first", 32'(rx_first), 32'(e.first));
          end
        end
      end
      valid_prev = rx_valid;
    end
  end

  task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 0; i < n; i++) begin
      if (SOR == 0) begin
        @(negedge clk);
        spi_sclk = 1'b1;
        spi_mosi = b[7-i];
        spi_dc   = dc;
        repeat (half) @(negedge clk);
        spi_sclk = 1'b0;
        last_sample_cyc = cyc;
        if (i == 7) -> last_bit_ev;
        repeat (half - 1) @(negedge clk);
      end else begin
        @(negedge clk);
        spi_mosi = b[7-i];
        spi_dc   = dc;
        repeat (half - 1) @(negedge clk);
        spi_sclk = 1'b1;
        last_sample_cyc = cyc;
        if (i == 7) -> last_bit_ev;
        repeat (half) @(negedge clk);
        spi_sclk = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc, input logic first);
    exp_t e;
    e.d = b;
    e.dc = dc;
    e.first = first;
    sb_q.push_back(e);
    send_bits(b, dc, 8);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ready_dir = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_dc"}, 32'(rx_dc), 32'd0);
    check({tag, "_rx_first"}, 32'(rx_first), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Command byte with latency measurement
    valid_hi_cnt = 0;
    cs_low();
    send_byte(8'h01, 1'b0, 1'b1);
    cs_high();
    check("cmd_latency", 32'(last_rise_cyc - last_sample_cyc), 32'(SS + 2));
    check("cmd_valid_cycles", 32'(valid_hi_cnt), 32'd1);
    drain("cmd_drain");

    // Multi-byte frame
    cs_low();
    send_byte(8'h2C, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h7F, 1'b1, 1'b0);
    cs_high();
    drain("multi_drain");

    // Backpressure: second byte is lost
    set_ready(1'b0);
    cs_low();
    send_byte(8'h11, 1'b1, 1'b1);
    send_bits(8'h22, 1'b1, 8);
    cs_high();
    check("bp_valid_held", 32'(rx_valid), 32'd1);
    check("bp_data_held", 32'(rx_data), 32'h11);
    check("bp_overrun_set", 32'(overrun), 32'd1);
    @(posedge clk);
    #1 ready_dir = 1'b1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    check("bp_overrun_clr", 32'(overrun), 32'd0);
    check("bp_valid_clr", 32'(rx_valid), 32'd0);
    drain("bp_drain");

    // Accept on exactly the completion cycle of the next byte
    set_ready(1'b0);
    cs_low();
    send_byte(8'h33, 1'b1, 1'b1);
    fork
      send_byte(8'h44, 1'b1, 1'b0);
      begin
        @(last_bit_ev);
        repeat (SS + 1) @(posedge clk);
        #1 ready_dir = 1'b1;
        @(posedge clk);
        #1 ready_dir = 1'b0;
      end
    join
    check("sim_overrun", 32'(overrun), 32'd0);
    check("sim_valid", 32'(rx_valid), 32'd1);
    check("sim_data", 32'(rx_data), 32'h44);
    cs_high();
    set_ready(1'b1);
    drain("sim_drain");

    // Abort after 5 bits, then a clean frame
    fe_cnt = 0;
    valid_hi_cnt = 0;
    cs_low();
    send_bits(8'hE8, 1'b1, 5);
    cs_high();
    check("abort_frame_err", 32'(fe_cnt), 32'd1);
    check("abort_no_valid", 32'(valid_hi_cnt), 32'd0);
    cs_low();
    send_byte(8'h55, 1'b1, 1'b1);
    cs_high();
    drain("abort_drain");

    // Reset in the middle of a byte
    cs_low();
    send_bits(8'hF0, 1'b1, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_low();
    send_byte(8'h0F, 1'b0, 1'b1);
    cs_high();
    drain("rst_drain");

    // Randomised frames with random backpressure and sclk period
    rand_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      nb = $urandom_range(1, 4);
      half = $urandom_range(3, 5);
      cs_low();
      for (int j = 0; j < nb; j++) begin
        send_byte(8'($urandom), 1'($urandom), (j == 0));
      end
      cs_high();
    end
    set_ready(1'b1);
    rand_mode = 1'b0;
    drain("rand_drain");
    check("rand_overrun", 32'(overrun), 32'd0);
    check("total_frame_err", 32'(fe_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
